// File: rtl/c1_input_ports.sv
// Controller/status input block: synchronises and debounces raw buttons, then
// serves one byte per zone read onto the upper half of the 68k data bus.
module c1_input_ports #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned DB_SAMPLES  = 4,
  parameter int unsigned TICK_DIV    = 256
) (
  input  logic                      CLK_24M,
  input  logic                      RESET,
  input  logic                      nCTRL1_ZONE,
  input  logic                      nCTRL2_ZONE,
  input  logic                      nSTATUSB_ZONE,
  input  logic                      nPORTSEL_WR,
  input  logic                      PORTSEL_D,
  input  logic [10*NUM_PLAYERS-1:0] P_IN,
  input  logic                      nWP,
  input  logic                      nCD2,
  input  logic                      nCD1,
  input  logic                      SYSTEM_MODE,
  output logic [15:8]               M68K_DATA,
  output logic                      DATA_OE
);

  localparam int unsigned NB = 10 * NUM_PLAYERS;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(DB_SAMPLES + 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DB_SAMPLES - 1);

  logic [NB-1:0] r_pin_s1, r_pin_s2, r_deb;
  logic [3:0]    r_st_s1, r_st_s2;
  logic [CW-1:0] r_db_cnt [NB];
  logic [PW-1:0] r_presc;
  logic          w_tick;
  logic          r_wr_prev, r_port_sel;
  logic [39:0]   w_deb_ext;
  logic [9:0]    w_a, w_b;
  logic [2:0]    w_zone, r_zone_prev, w_fall;
  logic          w_any_low, w_capture;
  logic [7:0]    w_byte, r_hold;
  logic          r_hold_valid;

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      r_pin_s1 <= '1;
      r_pin_s2 <= '1;
      r_st_s1  <= '1;
      r_st_s2  <= '1;
    end else begin
      r_pin_s1 <= P_IN;
      r_pin_s2 <= r_pin_s1;
      r_st_s1  <= {SYSTEM_MODE, nWP, nCD2, nCD1};
      r_st_s2  <= r_st_s1;
    end
  end

  assign w_tick = (r_presc == TICK_LAST);

  always_ff @(posedge CLK_24M) begin
    if (RESET)       r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  // Comparing against DB_SAMPLES-1 before incrementing keeps the counter from
  // ever holding DB_SAMPLES itself; load and clear happen on the same tick.
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      r_deb <= '1;
      for (int unsigned i = 0; i < NB; i++) r_db_cnt[i] <= '0;
    end else if (w_tick) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (r_pin_s2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == CNT_LAST) begin
          r_deb[i]    <= r_pin_s2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      r_wr_prev  <= 1'b1;
      r_port_sel <= 1'b0;
    end else begin
      r_wr_prev <= nPORTSEL_WR;
      if (NUM_PLAYERS == 4 && !r_wr_prev && nPORTSEL_WR) r_port_sel <= PORTSEL_D;
    end
  end

  // Pad to four players with released buttons so one mux serves both sizes.
  always_comb begin
    w_deb_ext           = '1;
    w_deb_ext[NB-1:0]   = r_deb;
    w_a = r_port_sel ? w_deb_ext[29:20] : w_deb_ext[9:0];
    w_b = r_port_sel ? w_deb_ext[39:30] : w_deb_ext[19:10];
  end

  assign w_zone    = {nSTATUSB_ZONE, nCTRL2_ZONE, nCTRL1_ZONE};
  assign w_fall    = r_zone_prev & ~w_zone;
  assign w_any_low = ~&w_zone;
  assign w_capture = |w_fall && !r_hold_valid;

  always_comb begin
    if (w_fall[0])      w_byte = w_a[7:0];
    else if (w_fall[1]) w_byte = w_b[7:0];
    else                w_byte = {r_st_s2, w_b[9:8], w_a[9:8]};
  end

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      r_zone_prev  <= '0;
      r_hold       <= '1;
      r_hold_valid <= 1'b0;
    end else begin
      r_zone_prev <= w_zone;
      if (w_capture) begin
        r_hold       <= w_byte;
        r_hold_valid <= 1'b1;
      end else if (!w_any_low) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  assign DATA_OE   = r_hold_valid & w_any_low & ~RESET;
  assign M68K_DATA = DATA_OE ? r_hold : 'z;

endmodule

// File: tb/tb_c1_input_ports.sv
// Scoreboard bench: a 4-player and a 2-player instance share stimulus; reads
// push expected bytes computed from a button-level model, a monitor pops them.
module tb_c1_input_ports;
  localparam int TD = 4;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        z1 = 1'b1, z2 = 1'b1, zs = 1'b1;
  logic        wr = 1'b1, pd = 1'b0;
  logic [39:0] p_in = '1;
  logic        nwp = 1'b1, ncd2 = 1'b1, ncd1 = 1'b1, smode = 1'b1;
  wire  [15:8] d4, d2;
  wire         oe4, oe2;

  always #5 clk = ~clk;

  c1_input_ports #(.NUM_PLAYERS(4), .DB_SAMPLES(DB), .TICK_DIV(TD)) u_dut4 (
    .CLK_24M(clk), .RESET(rst), .nCTRL1_ZONE(z1), .nCTRL2_ZONE(z2),
    .nSTATUSB_ZONE(zs), .nPORTSEL_WR(wr), .PORTSEL_D(pd), .P_IN(p_in),
    .nWP(nwp), .nCD2(ncd2), .nCD1(ncd1), .SYSTEM_MODE(smode),
    .M68K_DATA(d4), .DATA_OE(oe4));

  c1_input_ports #(.NUM_PLAYERS(2), .DB_SAMPLES(DB), .TICK_DIV(TD)) u_dut2 (
    .CLK_24M(clk), .RESET(rst), .nCTRL1_ZONE(z1), .nCTRL2_ZONE(z2),
    .nSTATUSB_ZONE(zs), .nPORTSEL_WR(wr), .PORTSEL_D(pd), .P_IN(p_in[19:0]),
    .nWP(nwp), .nCD2(ncd2), .nCD1(ncd1), .SYSTEM_MODE(smode),
    .M68K_DATA(d2), .DATA_OE(oe2));

  typedef struct packed {
    logic [7:0] b4;
    logic [7:0] b2;
    int         c;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [39:0] m_deb = '1;
  logic        m_psel = 1'b0;
  logic [3:0]  m_st = '1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [7:0] exp_byte(input int np, input logic [2:0] zm);
    logic [9:0] a, b;
    a = (np == 4 && m_psel) ? m_deb[29:20] : m_deb[9:0];
    b = (np == 4 && m_psel) ? m_deb[39:30] : m_deb[19:10];
    if (zm[0])      return a[7:0];
    else if (zm[1]) return b[7:0];
    else            return {m_st, b[9:8], a[9:8]};
  endfunction

  task automatic set_long(input logic [39:0] v);
    @(posedge clk); #1 p_in = v;
    repeat (5 * TD + 4) @(posedge clk);
    m_deb = v;
  endtask

  task automatic glitch(input logic [39:0] g);
    @(posedge clk); #1 p_in = g;
    repeat (2 * TD) @(posedge clk);
    #1 p_in = m_deb;
    repeat (2 * TD) @(posedge clk);
  endtask

  task automatic portsel(input logic b);
    @(posedge clk); #1 pd = b; wr = 1'b0;
    @(posedge clk); #1 wr = 1'b1;
    @(posedge clk); #1;
    m_psel = b;
  endtask

  task automatic set_status(input logic [3:0] v);
    @(posedge clk); #1 {smode, nwp, ncd2, ncd1} = v;
    m_st = v;
    repeat (3) @(posedge clk);
  endtask

  task automatic start_read(input logic [2:0] zm);
    exp_t e;
    @(posedge clk); #1;
    e.b4 = exp_byte(4, zm);
    e.b2 = exp_byte(2, zm);
    e.c  = cyc;
    q.push_back(e);
    {zs, z2, z1} = ~zm;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    check("read_served", q.size(), 0);
    q.delete();
  endtask

  task automatic end_read();
    @(posedge clk); #1 {zs, z2, z1} = 3'b111;
    @(posedge clk);
  endtask

  // Monitor: pops on each output-enable rise, then checks the bus stays frozen.
  initial begin : monitor
    exp_t       e;
    logic [7:0] cur4, cur2;
    logic       prev_oe;
    prev_oe = 1'b0;
    cur4 = '0;
    cur2 = '0;
    forever begin
      @(negedge clk);
      if (oe4 && !prev_oe) begin
        check("oe_has_expect", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          cur4 = e.b4;
          cur2 = e.b2;
          check("read_data_p4", d4, e.b4);
          check("read_oe_p2", oe2, 1);
          check("read_data_p2", d2, e.b2);
          check("read_latency", cyc - e.c, 1);
        end
      end else if (oe4) begin
        check("hold_frozen_p4", d4, cur4);
        if (oe2) check("hold_frozen_p2", d2, cur2);
      end
      if (z1 && z2 && zs) begin
        check("oe_idle_p4", oe4, 0);
        check("oe_idle_p2", oe2, 0);
      end
      prev_oe = oe4;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [39:0] v;
    logic [2:0]  zm;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_oe_p4", oe4, 0);
    check("reset_oe_p2", oe2, 0);
    #1 rst = 1'b0;

    // Button held low long enough is accepted.
    set_long(40'hFF_FFFF_FFFE);
    start_read(3'b001);
    end_read();

    // Two-tick glitch is rejected.
    set_long('1);
    glitch(40'hFF_FFFF_FFFE);
    start_read(3'b001);
    end_read();

    // Port select routes player 2 to CTRL1 on the 4-player instance only.
    set_long({10'h3FF, 10'h35A, 10'h3FF, 10'h3FF});
    portsel(1'b1);
    start_read(3'b001);
    end_read();

    // Simultaneous CTRL1 and STATUSB fall: CTRL1 wins.
    set_status(4'b0110);
    start_read(3'b101);
    end_read();

    // Debounced change during a read does not disturb the held byte.
    start_read(3'b010);
    set_long({$urandom(), $urandom()});
    end_read();
    start_read(3'b010);
    end_read();

    // Reset mid-read with the zone held low across release.
    start_read(3'b001);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("midread_reset_oe_p4", oe4, 0);
    check("midread_reset_oe_p2", oe2, 0);
    @(posedge clk); #1 rst = 1'b0;
    m_deb = '1;
    m_psel = 1'b0;
    repeat (5 * TD + 4) @(posedge clk);
    m_deb = p_in;
    @(negedge clk);
    check("post_reset_no_oe_p4", oe4, 0);
    check("post_reset_no_oe_p2", oe2, 0);
    end_read();
    start_read(3'b001);
    end_read();

    for (int it = 0; it < 40; it++) begin
      set_status(4'($urandom()));
      if ($urandom_range(0, 2) == 0) portsel(1'($urandom()));
      v = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) glitch(m_deb ^ v);
      else set_long(v);
      zm = 3'($urandom_range(1, 7));
      start_read(zm);
      repeat ($urandom_range(0, 4)) @(posedge clk);
      end_read();
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/c1_input_ports.md
C1_INPUT_PORTS -- requirements
Module: c1_input_ports

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of controller ports; legal values 2 or 4.
REQ-002 SHALL have parameter DB_SAMPLES, default 4, consecutive differing samples needed to accept a new button level; legal range 1..15.
REQ-003 SHALL have parameter TICK_DIV, default 256, CLK_24M cycles per debounce sample; legal range 2..65535.
REQ-004 SHALL have port CLK_24M  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports nCTRL1_ZONE, nCTRL2_ZONE, nSTATUSB_ZONE  in  1 each  active-low read selects, synchronous to CLK_24M.
REQ-007 SHALL have port nPORTSEL_WR  in  1  active-low port-select write strobe.
REQ-008 SHALL have port PORTSEL_D  in  1  port-select write data.
REQ-009 SHALL have port P_IN  in  10*NUM_PLAYERS  raw active-low buttons; player k at bits [10k+9:10k], k from 0.
REQ-010 SHALL have ports nWP, nCD2, nCD1, SYSTEM_MODE  in  1 each  raw status levels.
REQ-011 SHALL have port M68K_DATA  out  [15:8]  tri-stated read data.
REQ-012 SHALL have port DATA_OE  out  1  high while M68K_DATA is driven.

Function
REQ-013 SHALL pass every P_IN, nWP, nCD2, nCD1 and SYSTEM_MODE bit through a 2-flop synchroniser.
REQ-014 SHALL run a prescaler counting 0..TICK_DIV-1, wrapping to 0, and pulse tick for one cycle at TICK_DIV-1.
REQ-015 SHALL keep, per P_IN bit, a debounced level and a saturating counter of width ceil(log2(DB_SAMPLES+1)).
REQ-016 On tick, SHALL clear the bit's counter when the synchronised bit equals its debounced level, else increment it.
REQ-017 On the tick where the increment reaches DB_SAMPLES, SHALL load the synchronised value into the debounced level and clear the counter in the same cycle.
REQ-018 SHALL not debounce nWP, nCD2, nCD1 or SYSTEM_MODE; their synchronised values are used directly.
REQ-019 SHALL hold port_sel, a 1-bit register; on a cycle where nPORTSEL_WR was 0 last cycle and is 1 now, port_sel SHALL load PORTSEL_D as sampled that cycle.
REQ-020 With NUM_PLAYERS=2, port_sel SHALL be constant 0 and writes SHALL be ignored.
REQ-021 SHALL map port_sel=0 as A=player0, B=player1, and port_sel=1 as A=player2, B=player3.
REQ-022 SHALL register each zone input once (prev) to detect a falling edge: prev=1 and current=0.
REQ-023 On a falling edge, SHALL capture one byte into hold by priority CTRL1 > CTRL2 > STATUSB.
REQ-024 The captured byte SHALL be: CTRL1 = A[7:0]; CTRL2 = B[7:0]; STATUSB = {SYSTEM_MODE, nWP, nCD2, nCD1, B[9:8], A[9:8]}.
REQ-025 SHALL set hold_valid on the cycle after capture; output latency from zone fall is 1 cycle.
REQ-026 DATA_OE SHALL equal hold_valid AND (any zone low), combinationally.
REQ-027 M68K_DATA SHALL equal hold when DATA_OE=1 and 8'bz otherwise, so it releases in the same cycle a zone rises.
REQ-028 hold_valid SHALL clear on the first cycle with all zones high.
REQ-029 While a zone is held low, hold SHALL stay frozen; a debounced change or port_sel write during the read SHALL affect only the next capture.
REQ-030 A second zone falling while another is still low SHALL not recapture.

Reset
REQ-031 On RESET=1, SHALL set sync flops, debounced levels and hold to all-ones (released), counters and prescaler to 0, and port_sel and hold_valid to 0.
REQ-032 On RESET=1, SHALL set zone prev registers to 0, so a zone already low at reset release SHALL not capture until it rises and falls again.
REQ-033 During RESET=1, DATA_OE SHALL be 0 and M68K_DATA SHALL be high-Z.

Verification (bench with TICK_DIV=4, DB_SAMPLES=3, NUM_PLAYERS=4)
REQ-034 Player0 bit0 held at 0 for 3 ticks after reset, then nCTRL1_ZONE low -> M68K_DATA=8'hFE one cycle after zone fall, with DATA_OE=1.
REQ-035 Player0 bit0 at 0 for 2 ticks, then back to 1 for 1 tick -> debounced level stays 1 and CTRL1 read returns 8'hFF.
REQ-036 PORTSEL_D=1 with an nPORTSEL_WR 0->1 pulse, player2 bits[7:0] steady at 8'h5A -> CTRL1 read returns 8'h5A; with NUM_PLAYERS=2 the same sequence returns player0 data.
REQ-037 nCTRL1_ZONE and nSTATUSB_ZONE fall in the same cycle -> CTRL1 byte captured; zone rise -> M68K_DATA high-Z and DATA_OE=0 that same cycle.
REQ-038 Debounced change during an active read -> hold unchanged until the zone rises and falls again.
REQ-039 RESET asserted mid-read with zone held low through release -> output stays high-Z until the zone toggles high and then low.
